// File: rtl/rc4_crack_core.sv
// rc4_crack_core: brute-force RC4 key search over an inclusive candidate range.
// Per candidate: fill S with identity, run the key schedule, then decrypt the
// ciphertext byte by byte, aborting on the first non-text character.
// s_memory / e_ROM reads take one wait state: the address is driven in one
// state and s_q / e_q are sampled on the clock edge that ends the following state.
// Optional macro RC4_UPPERCASE_EN: also accept 'A'..'Z' as valid plaintext.
module rc4_crack_core #(
  parameter int KEY_BYTES = 3,
  parameter int KEY_BITS  = 22,
  parameter int MSG_LEN   = 32,
  parameter int MSG_AW    = 5
) (
  input  logic                CLOCK_50,
  input  logic                reset,
  input  logic                start,
  input  logic [KEY_BITS-1:0] key_start,
  input  logic [KEY_BITS-1:0] key_end,
  output logic                busy,
  output logic                found,
  output logic                exhausted,
  output logic [KEY_BITS-1:0] key_out,
  output logic [7:0]          s_address,
  output logic [7:0]          s_data,
  output logic                s_wren,
  input  logic [7:0]          s_q,
  output logic [MSG_AW-1:0]   e_address,
  input  logic [7:0]          e_q,
  output logic [MSG_AW-1:0]   d_address,
  output logic [7:0]          d_data,
  output logic                d_wren
);
  localparam int KBW = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
  localparam logic [MSG_AW-1:0] K_LAST = MSG_AW'(MSG_LEN - 1);
  localparam logic [KBW-1:0]    KB_TOP = KBW'(KEY_BYTES - 1);

  typedef enum logic [4:0] {
    IDLE, FILL,
    SW_RI, SW_WI, SW_RJ, SW_WJ, SW_WRI, SW_WRJ,
    DC_INC, DC_RI, DC_WI, DC_RJ, DC_WJ, DC_SWI, DC_SWJ, DC_RF, DC_WF, DC_WR,
    DONE
  } state_t;

  // All architectural state, registered as one unit so reset clears everything.
  typedef struct packed {
    state_t              st;
    logic [7:0]          i;
    logic [7:0]          j;
    logic [7:0]          si;
    logic [7:0]          sj;
    logic [MSG_AW-1:0]   k;
    logic [KBW-1:0]      kb;     // packed index of the key byte for i mod KEY_BYTES
    logic [KEY_BITS-1:0] cand;
    logic [KEY_BITS-1:0] kend;
    logic                busy;
    logic                found;
    logic                exhausted;
    logic [7:0]          s_addr;
    logic [7:0]          s_data;
    logic                s_wren;
    logic [MSG_AW-1:0]   e_addr;
    logic [MSG_AW-1:0]   d_addr;
    logic [7:0]          d_data;
    logic                d_wren;
  } regs_t;

  regs_t r, nx;

  // Key byte 0 is the most significant byte, so the schedule walks the packed
  // array from the top index down and wraps; this stands in for i mod KEY_BYTES.
  logic [KEY_BYTES-1:0][7:0] key_bytes;
  logic [7:0]                kbyte;
  logic [7:0]                p;

  assign key_bytes = (KEY_BYTES*8)'(r.cand);
  assign kbyte     = key_bytes[r.kb];
  assign p         = s_q ^ e_q;

  function automatic logic is_text(input logic [7:0] c);
`ifdef RC4_UPPERCASE_EN
    return (c >= 8'd97 && c <= 8'd122) || (c == 8'd32) || (c >= 8'd65 && c <= 8'd90);
`else
    return (c >= 8'd97 && c <= 8'd122) || (c == 8'd32);
`endif
  endfunction

  // Start a fresh candidate: first FILL write (S[0]=0) is driven immediately.
  function automatic regs_t enter_fill(input regs_t x);
    regs_t y;
    y        = x;
    y.i      = 8'd0;
    y.s_addr = 8'd0;
    y.s_data = 8'd0;
    y.s_wren = 1'b1;
    y.st     = FILL;
    return y;
  endfunction

  assign busy      = r.busy;
  assign found     = r.found;
  assign exhausted = r.exhausted;
  assign key_out   = r.cand;
  assign s_address = r.s_addr;
  assign s_data    = r.s_data;
  assign s_wren    = r.s_wren;
  assign e_address = r.e_addr;
  assign d_address = r.d_addr;
  assign d_data    = r.d_data;
  assign d_wren    = r.d_wren;

  // State register with synchronous active-low reset.
  always_ff @(posedge CLOCK_50) begin
    if (!reset) r <= '0;
    else        r <= nx;
  end

  // Next-state and next-output logic; write enables are single-cycle pulses.
  always_comb begin
    nx        = r;
    nx.s_wren = 1'b0;
    nx.d_wren = 1'b0;
    case (r.st)
      IDLE, DONE: begin
        if (start) begin
          nx.cand  = key_start;
          nx.kend  = key_end;
          nx.found = 1'b0;
          if (key_start > key_end) begin
            nx.exhausted = 1'b1;
            nx.busy      = 1'b0;
            nx.st        = DONE;
          end else begin
            nx.exhausted = 1'b0;
            nx.busy      = 1'b1;
            nx           = enter_fill(nx);
          end
        end
      end
      FILL: begin
        if (r.i == 8'hFF) begin
          nx.i      = 8'd0;
          nx.j      = 8'd0;
          nx.kb     = KB_TOP;
          nx.s_addr = 8'd0;
          nx.st     = SW_RI;
        end else begin
          nx.i      = r.i + 8'd1;
          nx.s_addr = r.i + 8'd1;
          nx.s_data = r.i + 8'd1;
          nx.s_wren = 1'b1;
        end
      end
      SW_RI: nx.st = SW_WI;
      SW_WI: begin
        nx.si     = s_q;
        nx.j      = r.j + s_q + kbyte;
        nx.s_addr = r.j + s_q + kbyte;
        nx.st     = SW_RJ;
      end
      SW_RJ: nx.st = SW_WJ;
      SW_WJ: begin
        nx.sj     = s_q;
        nx.s_addr = r.i;
        nx.s_data = s_q;
        nx.s_wren = 1'b1;
        nx.st     = SW_WRI;
      end
      SW_WRI: begin
        nx.s_addr = r.j;
        nx.s_data = r.si;
        nx.s_wren = 1'b1;
        nx.st     = SW_WRJ;
      end
      SW_WRJ: begin
        nx.kb = (r.kb == '0) ? KB_TOP : r.kb - 1'b1;
        if (r.i == 8'hFF) begin
          nx.i  = 8'd0;
          nx.j  = 8'd0;
          nx.k  = '0;
          nx.st = DC_INC;
        end else begin
          nx.i      = r.i + 8'd1;
          nx.s_addr = r.i + 8'd1;
          nx.st     = SW_RI;
        end
      end
      DC_INC: begin
        nx.i      = r.i + 8'd1;
        nx.s_addr = r.i + 8'd1;
        nx.st     = DC_RI;
      end
      DC_RI: nx.st = DC_WI;
      DC_WI: begin
        nx.si     = s_q;
        nx.j      = r.j + s_q;
        nx.s_addr = r.j + s_q;
        nx.st     = DC_RJ;
      end
      DC_RJ: nx.st = DC_WJ;
      DC_WJ: begin
        nx.sj     = s_q;
        nx.s_addr = r.i;
        nx.s_data = s_q;
        nx.s_wren = 1'b1;
        nx.st     = DC_SWI;
      end
      DC_SWI: begin
        nx.s_addr = r.j;
        nx.s_data = r.si;
        nx.s_wren = 1'b1;
        nx.st     = DC_SWJ;
      end
      DC_SWJ: begin
        nx.s_addr = r.si + r.sj;
        nx.e_addr = r.k;
        nx.st     = DC_RF;
      end
      DC_RF: nx.st = DC_WF;
      DC_WF: begin
        if (is_text(p)) begin
          nx.d_addr = r.k;
          nx.d_data = p;
          nx.d_wren = 1'b1;
          nx.st     = DC_WR;
        end else if (r.cand == r.kend) begin
          // Compare before incrementing so the counter never wraps past key_end.
          nx.exhausted = 1'b1;
          nx.busy      = 1'b0;
          nx.st        = DONE;
        end else begin
          nx.cand = r.cand + 1'b1;
          nx      = enter_fill(nx);
        end
      end
      DC_WR: begin
        if (r.k == K_LAST) begin
          nx.found = 1'b1;
          nx.busy  = 1'b0;
          nx.st    = DONE;
        end else begin
          nx.k  = r.k + 1'b1;
          nx.st = DC_INC;
        end
      end
      default: nx.st = IDLE;
    endcase
  end
endmodule

// File: tb/tb_rc4_crack_core.sv
// tb_rc4_crack_core: directed bench with behavioural RC4 model and memory models.
module tb_rc4_crack_core;
  localparam int KB    = 22;
  localparam int ML    = 32;
  localparam int AW    = 5;
  localparam int LIMIT = 40000;

  logic          CLOCK_50 = 1'b0;
  logic          reset    = 1'b0;
  logic          start    = 1'b0;
  logic [KB-1:0] key_start = '0;
  logic [KB-1:0] key_end   = '0;
  logic          busy, found, exhausted;
  logic [KB-1:0] key_out;
  logic [7:0]    s_address, s_data, s_q, e_q, d_data;
  logic          s_wren, d_wren;
  logic [AW-1:0] e_address, d_address;

  int errors = 0;
  int checks = 0;

  always #10 CLOCK_50 = ~CLOCK_50;

  rc4_crack_core #(.KEY_BYTES(3), .KEY_BITS(KB), .MSG_LEN(ML), .MSG_AW(AW)) dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .start(start),
    .key_start(key_start), .key_end(key_end),
    .busy(busy), .found(found), .exhausted(exhausted), .key_out(key_out),
    .s_address(s_address), .s_data(s_data), .s_wren(s_wren), .s_q(s_q),
    .e_address(e_address), .e_q(e_q),
    .d_address(d_address), .d_data(d_data), .d_wren(d_wren)
  );

  // Memory models: registered address, data valid after the next edge.
  logic [7:0]    s_mem [0:255];
  logic [7:0]    e_rom [0:ML-1];
  logic [7:0]    d_mem [0:ML-1];
  logic [7:0]    s_addr_r;
  logic [AW-1:0] e_addr_r;

  always @(posedge CLOCK_50) begin
    if (s_wren) s_mem[s_address] <= s_data;
    if (d_wren) d_mem[d_address] <= d_data;
    s_addr_r <= s_address;
    e_addr_r <= e_address;
  end
  assign s_q = s_mem[s_addr_r];
  assign e_q = e_rom[e_addr_r];

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic ok_char(input logic [7:0] c);
`ifdef RC4_UPPERCASE_EN
    return (c >= "a" && c <= "z") || c == " " || (c >= "A" && c <= "Z");
`else
    return (c >= "a" && c <= "z") || c == " ";
`endif
  endfunction

  // Textbook RC4 keystream for a 3-byte key (byte 0 = most significant).
  logic [7:0] ks_buf [0:ML-1];
  task automatic rc4_stream(input logic [23:0] key);
    int S[256];
    int i, j, t;
    for (int n = 0; n < 256; n++) S[n] = n;
    j = 0;
    for (int n = 0; n < 256; n++) begin
      j = (j + S[n] + int'((key >> (8 * (2 - n % 3))) & 24'hFF)) % 256;
      t = S[n]; S[n] = S[j]; S[j] = t;
    end
    i = 0; j = 0;
    for (int k = 0; k < ML; k++) begin
      i = (i + 1) % 256;
      j = (j + S[i]) % 256;
      t = S[i]; S[i] = S[j]; S[j] = t;
      ks_buf[k] = 8'(S[(S[i] + S[j]) % 256]);
    end
  endtask

  task automatic load_rom(input logic [255:0] msg, input logic [23:0] key);
    rc4_stream(key);
    for (int n = 0; n < ML; n++) e_rom[n] = msg[255 - 8*n -: 8] ^ ks_buf[n];
  endtask

  // Expected search result: first key in range whose decryption is all text.
  task automatic model_search(input logic [KB-1:0] ks, input logic [KB-1:0] ke,
                              output logic f, output logic [KB-1:0] k);
    f = 1'b0;
    k = ke;
    for (int c = int'(ks); c <= int'(ke) && !f; c++) begin
      logic ok;
      rc4_stream(24'(c));
      ok = 1'b1;
      for (int n = 0; n < ML; n++) if (!ok_char(e_rom[n] ^ ks_buf[n])) ok = 1'b0;
      if (ok) begin
        f = 1'b1;
        k = KB'(c);
      end
    end
  endtask

  // Pulse start and follow the search cycle by cycle until busy drops.
  task automatic run_search(input logic [KB-1:0] ks, input logic [KB-1:0] ke, output int cyc);
    logic [KB-1:0] last;
    int            exp_k;
    logic          have;
    @(negedge CLOCK_50);
    key_start = ks; key_end = ke; start = 1'b1;
    @(negedge CLOCK_50);
    start = 1'b0;
    cyc = 0; have = 1'b0; exp_k = 0; last = ks;
    while (busy && cyc < LIMIT) begin
      check("key_in_range", 72'(key_out >= ks && key_out <= ke && key_out >= last), 72'd1);
      if (!have || key_out != last) begin
        rc4_stream({2'b00, key_out});
        last = key_out; have = 1'b1; exp_k = 0;
      end
      if (d_wren) begin
        check("d_addr_seq", 72'(d_address), 72'(exp_k));
        check("d_data", 72'(d_data), 72'(e_rom[d_address] ^ ks_buf[d_address]));
        exp_k++;
      end
      @(negedge CLOCK_50);
      cyc++;
    end
    check("search_done", 72'(busy), 72'd0);
    check("one_outcome", 72'(found ^ exhausted), 72'd1);
    for (int n = 0; n < 3; n++) begin
      check("wren_after_done", 72'({s_wren, d_wren}), 72'd0);
      @(negedge CLOCK_50);
    end
  endtask

  initial begin
    logic          f;
    logic [KB-1:0] k;
    int            cyc, nbad;
    logic          bad;
    logic [71:0]   pt, ct, acc;
    logic [255:0]  msg1, msg2;
    logic          exp_upper;

    // Reset state
    repeat (3) @(negedge CLOCK_50);
    check("reset_outputs", 72'({busy, found, exhausted, key_out, s_address, s_data, s_wren,
                                e_address, d_address, d_data, d_wren}), 72'd0);
    reset = 1'b1;

    // Pin the model: published RC4 vector, key "Key", plaintext "Plaintext"
    pt = "Plaintext";
    ct = 72'hBBF316E8D940AF0AD3;
    rc4_stream(24'h4B6579);
    acc = '0;
    for (int n = 0; n < 9; n++) acc[71 - 8*n -: 8] = pt[71 - 8*n -: 8] ^ ks_buf[n];
    check("model_rc4_vector", acc, ct);
    check("model_char_backtick", 72'(ok_char(8'h60)), 72'd0);
    check("model_char_z", 72'(ok_char(8'h7A)), 72'd1);

    msg1 = "the quick brown fox jumps over a";
    msg2 = "The quick brown fox jumps over a";
    load_rom(msg1, 24'h00033C);

    // Single-key hit
    model_search(22'h33C, 22'h33C, f, k);
    run_search(22'h33C, 22'h33C, cyc);
    check("hit_found_model", 72'(found), 72'(f));
    check("hit_found", 72'(found), 72'd1);
    check("hit_exhausted", 72'(exhausted), 72'd0);
    check("hit_key", 72'(key_out), 72'h33C);
    check("hit_busy_cycles", 72'(cyc >= 256 + 1536), 72'd1);
    nbad = 0;
    for (int n = 0; n < ML; n++) if (d_mem[n] !== msg1[255 - 8*n -: 8]) nbad++;
    check("hit_d_mem", 72'(nbad), 72'd0);

    // Range search
    model_search(22'h330, 22'h340, f, k);
    run_search(22'h330, 22'h340, cyc);
    check("range_found_model", 72'(found), 72'(f));
    check("range_key_model", 72'(key_out), 72'(k));
    check("range_key", 72'(key_out), 72'h33C);

    // Exhaustion
    model_search(22'h0, 22'h5, f, k);
    run_search(22'h0, 22'h5, cyc);
    check("exh_found_model", 72'(found), 72'(f));
    check("exh_exhausted", 72'(exhausted), 72'd1);
    check("exh_found", 72'(found), 72'd0);
    check("exh_key", 72'(key_out), 72'h5);

    // Empty range
    @(negedge CLOCK_50);
    key_start = 22'h10; key_end = 22'h0F; start = 1'b1;
    @(negedge CLOCK_50);
    start = 1'b0;
    check("empty_exhausted", 72'(exhausted), 72'd1);
    check("empty_found", 72'(found), 72'd0);
    bad = 1'b0;
    for (int n = 0; n < 5; n++) begin
      if (busy !== 1'b0) bad = 1'b1;
      @(negedge CLOCK_50);
    end
    check("empty_never_busy", 72'(bad), 72'd0);

    // Reset during the key schedule
    @(negedge CLOCK_50);
    key_start = 22'h33C; key_end = 22'h33C; start = 1'b1;
    @(negedge CLOCK_50);
    start = 1'b0;
    repeat (256 + 200) @(negedge CLOCK_50);
    check("swap_busy", 72'({busy, key_out}), 72'({1'b1, 22'h33C}));
    reset = 1'b0;
    @(negedge CLOCK_50);
    reset = 1'b1;
    check("midreset_outputs", 72'({busy, found, exhausted, key_out, s_address, s_data, s_wren,
                                   e_address, d_address, d_data, d_wren}), 72'd0);
    run_search(22'h33C, 22'h33C, cyc);
    check("post_reset_found", 72'(found), 72'd1);
    check("post_reset_key", 72'(key_out), 72'h33C);

    // Uppercase plaintext
    load_rom(msg2, 24'h000101);
`ifdef RC4_UPPERCASE_EN
    exp_upper = 1'b1;
`else
    exp_upper = 1'b0;
`endif
    model_search(22'h101, 22'h101, f, k);
    run_search(22'h101, 22'h101, cyc);
    check("upper_found_model", 72'(found), 72'(f));
    check("upper_found", 72'(found), 72'(exp_upper));
    check("upper_exhausted", 72'(exhausted), 72'(!exp_upper));
    check("upper_key", 72'(key_out), 72'h101);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/rc4_crack_core.md
Name: rc4_crack_core

Overview:
- Parametrised RC4 brute-force key search engine. Successor to the lab4 fixed 3-byte / 22-bit / 32-character cracker.
- For each candidate key in a programmable inclusive range, it runs three phases against external single-port memories:
  - fill S[0..255] with 0..255;
  - key-schedule swap;
  - PRGA decrypt of MSG_LEN ciphertext bytes.
- Stops on the first key whose plaintext is entirely valid characters, or when the range is exhausted.
- Sits between the board top level (switches, LEDs) and the s_memory, d_memory and e_ROM instances.

Parameters:
- KEY_BYTES, 3: RC4 key length in bytes. Key byte 0 is the most significant byte.
- KEY_BITS, 22: searched key bits; must be ≤ KEY_BYTES*8. Upper key bits are zero.
- MSG_LEN, 32: ciphertext/plaintext length in bytes, range 1..2**MSG_AW.
- MSG_AW, 5: address width of e_ROM and d_memory.

Ports:
- CLOCK_50 in 1: system clock.
- reset in 1: synchronous, active-low.
- start in 1: one-cycle pulse; begins a search when idle.
- key_start in KEY_BITS: first candidate; sampled on start.
- key_end in KEY_BITS: last candidate, inclusive; sampled on start.
- busy out 1: search in progress.
- found out 1: last search found a key.
- exhausted out 1: last search ended with no key found.
- key_out out KEY_BITS: current candidate while busy; matching/last key when done.
- s_address out 8, s_data out 8, s_wren out 1, s_q in 8: S memory port.
- e_address out MSG_AW, e_q in 8: ciphertext ROM port.
- d_address out MSG_AW, d_data out 8, d_wren out 1: plaintext RAM port.

Behaviour:
- Reset (reset==0 at a clock edge), whether idle or mid-operation:
  - state←IDLE;
  - busy, found, exhausted, s_wren, d_wren, key_out, all addresses and data ← 0.
  - Memory contents are not cleared.
- Memory timing: s_q and e_q are valid on the second rising edge after the address is driven, so every read has one wait state.
- Writes are single-cycle with wren high.
- IDLE:
  - start=1 → latch the range, key_out←key_start, clear found/exhausted, busy←1, go to FILL.
  - start is ignored while busy.
  - If key_start > key_end: busy stays 0 and exhausted←1 on the next cycle.
- FILL:
  - Writes S[n]=n for n=0..255, one per cycle (256 cycles).
  - i←0, j←0.
- SWAP, per i: READ_I, WAIT, COMPUTE_J, WAIT, WRITE_I, WRITE_J (6 cycles per i).
  - j ← (j + S[i] + key[i mod KEY_BYTES]) mod 256.
  - key[b] = bits [(KEY_BYTES-b)*8-1 -: 8] of the zero-extended candidate.
  - i mod KEY_BYTES is held in a wrapping counter; no divider.
  - Write S[i]←S[j], then S[j]←S[i].
  - Exit after i=255; i, j, k ← 0.
- DECRYPT, per k:
  - i←i+1;
  - read S[i]; j←j+S[i];
  - read S[j];
  - swap;
  - read S[(S[i]+S[j]) mod 256] and e_ROM[k];
  - p = f XOR e_q.
  - All 8-bit arithmetic wraps mod 256.
- Character validity: p valid iff 97≤p≤122 or p==32.
- On valid p:
  - d_memory[k]←p, d_wren high for exactly one cycle.
  - If k==MSG_LEN-1: found←1, busy←0, key_out holds the matching key, go to DONE. Otherwise k←k+1.
- On invalid p:
  - Abort the candidate immediately; d_memory keeps stale partial data.
  - If candidate==key_end: exhausted←1, busy←0, key_out=key_end, go to DONE.
  - Otherwise candidate←candidate+1 and go to FILL.
  - The candidate counter never wraps past key_end, including when key_end = 2**KEY_BITS-1.
- DONE:
  - Holds outputs; all wren signals 0.
  - A new start pulse returns to the IDLE start behaviour and begins a new search.
- Simultaneous start and reset==0: reset wins.

Optional Feature:
- Macro RC4_UPPERCASE_EN.
- Defined: 65≤p≤90 is also valid, in addition to lowercase and space.
- Undefined: only lowercase 97..122 and space 32 are valid; uppercase bytes reject the key.

Test Plan:
- Single-key hit: e_ROM = 32-byte ciphertext of "the quick brown fox jumps over a" under key 0x00033C; start with range 0x00033C..0x00033C → found=1, exhausted=0, key_out=0x00033C, d_memory matches plaintext, busy high ≥ 256+1536 cycles.
- Range search: same ROM, range 0x000330..0x000340 → found=1, key_out=0x00033C; no d_wren occurs after found rises.
- Exhaustion: same ROM, range 0x000000..0x000005 → exhausted=1, found=0, key_out=0x000005.
- Empty range: key_start=0x10, key_end=0x0F → exhausted=1 one cycle after start, busy never asserted.
- Reset mid-SWAP: reset=0 for one cycle during SWAP → all outputs 0 next cycle; a fresh start with range 0x00033C..0x00033C still finds 0x00033C.
- Uppercase: plaintext "The quick..." under key 0x000101, range 0x000101..0x000101 → exhausted=1 without RC4_UPPERCASE_EN; found=1 with it defined.
